// File: rtl/cmd_frame_if.sv
// Received-byte stream handed from the UART RX path to the command-frame controller.
interface cmd_frame_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/cmd_frame_ctrl.sv
// Command-frame controller for the core-switch board.
// Parses HDR0 HDR1 payload[PAYLOAD_LEN] TAIL0 TAIL1 frames from the RX byte stream,
// enforces an inter-byte timeout and executes host-select / CPU-reset / power opcodes.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | hunting for HDR0, other bytes dropped silently
//   S_HDR   | HDR0 seen, expecting HDR1
//   S_BODY  | collecting payload bytes and the running checksum
//   S_TAIL0 | payload complete, expecting TAIL0
//   S_TAIL1 | expecting TAIL1; checksum verified and opcode executed on accept
//   S_EXEC  | one cycle after a good frame; requested reset pulses start here
//
// Opcode results (cmd_valid, force_swi, sel_host, power_on, bad-opcode error) are
// registered on the TAIL1 byte so they show up in the EXEC cycle. Reset counters are
// loaded at the end of EXEC so reset_n drops the cycle after EXEC.
module cmd_frame_ctrl #(
    parameter int         NUM_CH      = 2,
    parameter int         PAYLOAD_LEN = 4,
    parameter logic [7:0] HDR0        = 8'hEB,
    parameter logic [7:0] HDR1        = 8'h90,
    parameter logic [7:0] TAIL0       = 8'h09,
    parameter logic [7:0] TAIL1       = 8'hD7,
    parameter logic [7:0] BOARD_ID    = 8'hAB,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         RESET_CYC   = 100000,
    localparam int        CH_W        = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    cmd_frame_if.slave        rx,
    input  logic [CH_W-1:0]   active_host,
    output logic              cmd_valid,
    output logic [7:0]        cmd_op,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic [CH_W-1:0]   sel_host,
    output logic              force_swi,
    output logic [NUM_CH-1:0] reset_n,
    output logic [NUM_CH-1:0] power_on
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int RST_W = $clog2(RESET_CYC + 1);
    localparam int IDX_W = $clog2(PAYLOAD_LEN + 1);

    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RESET_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_BODY,
        S_TAIL0,
        S_TAIL1,
        S_EXEC
    } state_t;

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        id_q, id_d;
    logic [7:0]        op_q, op_d;
    logic [NUM_CH-1:0] rst_req_q, rst_req_d;
    logic [RST_W-1:0]  rst_cnt_q [NUM_CH];
    logic [RST_W-1:0]  rst_cnt_d [NUM_CH];
    logic [NUM_CH-1:0] reset_n_q, reset_n_d;
    logic [NUM_CH-1:0] power_q, power_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [7:0]        cmd_op_q, cmd_op_d;
    logic              frame_err_q, frame_err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [CH_W-1:0]   sel_host_q, sel_host_d;
    logic              force_swi_q, force_swi_d;

    logic              timed_out;
    logic [3:0]        k;
    logic [CH_W-1:0]   k_ch;
    logic              k_ok;
    logic              op_good;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            id_q        <= '0;
            op_q        <= '0;
            rst_req_q   <= '0;
            rst_cnt_q   <= '{default: '0};
            reset_n_q   <= '1;
            power_q     <= '1;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= '0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            sel_host_q  <= '0;
            force_swi_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            id_q        <= id_d;
            op_q        <= op_d;
            rst_req_q   <= rst_req_d;
            rst_cnt_q   <= rst_cnt_d;
            reset_n_q   <= reset_n_d;
            power_q     <= power_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            sel_host_q  <= sel_host_d;
            force_swi_q <= force_swi_d;
        end
    end

    // Frame parser, inter-byte timeout and opcode execution.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        id_d        = id_q;
        op_d        = op_q;
        rst_req_d   = '0;
        power_d     = power_q;
        cmd_valid_d = 1'b0;
        cmd_op_d    = cmd_op_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        sel_host_d  = sel_host_q;
        force_swi_d = 1'b0;
        k           = op_q[3:0];
        k_ch        = k[CH_W-1:0];
        k_ok        = (int'(k) < NUM_CH);
        op_good     = 1'b0;

        // Timer reloads on every byte; it only counts down while a frame is open.
        if (rx.rx_valid) begin
            tmo_d = TMO_LOAD;
        end else if (state_q != S_IDLE && state_q != S_EXEC && tmo_q != '0) begin
            tmo_d = tmo_q - TMO_W'(1);
        end

        // A byte in the expiry cycle wins, hence the rx_valid qualifier.
        timed_out = (state_q != S_IDLE) && (state_q != S_EXEC) &&
                    !rx.rx_valid && (tmo_q == '0);

        if (timed_out) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
            state_d     = S_IDLE;
        end else begin
            case (state_q)
                S_HDR: begin
                    if (rx.rx_valid) begin
                        if (rx.rx_data == HDR1) begin
                            state_d = S_BODY;
                            sum_d   = '0;
                            idx_d   = '0;
                        end else begin
                            frame_err_d = 1'b1;
                            err_code_d  = 2'd0;
                            state_d     = S_IDLE;
                        end
                    end
                end
                S_BODY: begin
                    if (rx.rx_valid) begin
                        sum_d = sum_q + rx.rx_data;
                        if (idx_q == IDX_W'(1)) id_d = rx.rx_data;
                        if (idx_q == IDX_W'(2)) op_d = rx.rx_data;
                        if (idx_q == IDX_LAST) begin
                            state_d = S_TAIL0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                S_TAIL0: begin
                    if (rx.rx_valid) begin
                        if (rx.rx_data == TAIL0) begin
                            state_d = S_TAIL1;
                        end else begin
                            frame_err_d = 1'b1;
                            err_code_d  = 2'd2;
                            state_d     = S_IDLE;
                        end
                    end
                end
                S_TAIL1: begin
                    if (rx.rx_valid) begin
                        if (rx.rx_data != TAIL1 || sum_q != 8'h00) begin
                            frame_err_d = 1'b1;
                            err_code_d  = 2'd2;
                            state_d     = S_IDLE;
                        end else begin
                            state_d = S_EXEC;
                            // Frames for other boards are dropped without any output.
                            if (id_q == BOARD_ID) begin
                                op_good = 1'b1;
                                if (op_q == 8'hFF) begin
                                    rst_req_d   = '1;
                                    sel_host_d  = '0;
                                    force_swi_d = 1'b1;
                                end else if (k_ok && op_q[7:4] == 4'h0) begin
                                    sel_host_d  = k_ch;
                                    force_swi_d = 1'b1;
                                end else if (k_ok && op_q[7:4] == 4'h1) begin
                                    if (k_ch != active_host) rst_req_d[k_ch] = 1'b1;
                                end else if (k_ok && op_q[7:4] == 4'h2) begin
                                    power_d[k_ch] = 1'b1;
                                end else if (k_ok && op_q[7:4] == 4'h3) begin
                                    if (k_ch != active_host) power_d[k_ch] = 1'b0;
                                end else begin
                                    op_good = 1'b0;
                                end
                                if (op_good) begin
                                    cmd_valid_d = 1'b1;
                                    cmd_op_d    = op_q;
                                end else begin
                                    frame_err_d = 1'b1;
                                    err_code_d  = 2'd3;
                                end
                            end
                        end
                    end
                end
                default: begin
                    // S_IDLE and S_EXEC: a byte during EXEC is treated like an IDLE byte.
                    state_d = S_IDLE;
                    if (rx.rx_valid && rx.rx_data == HDR0) state_d = S_HDR;
                end
            endcase
        end
    end

    // Per-channel reset pulse timers; a new request restarts a running pulse.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            rst_cnt_d[i] = rst_cnt_q[i];
            if (state_q == S_EXEC && rst_req_q[i]) begin
                rst_cnt_d[i] = RST_LOAD;
            end else if (rst_cnt_q[i] != '0) begin
                rst_cnt_d[i] = rst_cnt_q[i] - RST_W'(1);
            end
            reset_n_d[i] = (rst_cnt_d[i] == '0);
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_op_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign sel_host  = sel_host_q;
    assign force_swi = force_swi_q;
    assign reset_n   = reset_n_q;
    assign power_on  = power_q;

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Directed bench for cmd_frame_ctrl: a table of single-frame vectors plus hand-written
// sequences for header error, timeout, reset pulses and mid-frame reset.
module tb_cmd_frame_ctrl;

    localparam int NUM_CH = 2;
    localparam int CH_W   = 1;
    localparam int TMO    = 20;
    localparam int RCYC   = 30;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH_W-1:0]   active_host = '0;
    logic              cmd_valid;
    logic [7:0]        cmd_op;
    logic              frame_err;
    logic [1:0]        err_code;
    logic [CH_W-1:0]   sel_host;
    logic              force_swi;
    logic [NUM_CH-1:0] reset_n;
    logic [NUM_CH-1:0] power_on;

    cmd_frame_if rx_if ();

    cmd_frame_ctrl #(
        .NUM_CH(NUM_CH), .PAYLOAD_LEN(4), .TIMEOUT_CYC(TMO), .RESET_CYC(RCYC)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx_if), .active_host(active_host),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .frame_err(frame_err),
        .err_code(err_code), .sel_host(sel_host), .force_swi(force_swi),
        .reset_n(reset_n), .power_on(power_on)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cv_cnt = 0, fe_cnt = 0, fsw_cnt = 0;

    // Count pulse-cycles so single-cycle width and error presence can be checked.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) cv_cnt++;
            if (frame_err) fe_cnt++;
            if (force_swi) fsw_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives one byte sampled on the next posedge, returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] pay, input logic [7:0] t0);
        send_byte(8'hEB);
        send_byte(8'h90);
        send_byte(pay[31:24]);
        send_byte(pay[23:16]);
        send_byte(pay[15:8]);
        send_byte(pay[7:0]);
        send_byte(t0);
        send_byte(8'hD7);
    endtask

    task automatic measure_low(input int ch, output int n);
        n = 0;
        while (reset_n[ch] == 1'b0 && n < RCYC + 10) begin
            n++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        string           name;
        logic [CH_W-1:0] ah;
        logic [31:0]     pay;
        logic [7:0]      t0;
        int              n_cv;
        int              n_fe;
        int              n_fsw;
        logic [1:0]      ec;
        logic [CH_W-1:0] sel;
        logic [7:0]      op;
        logic [1:0]      pwr;
    } vec_t;

    function automatic vec_t mk(string nm, logic [CH_W-1:0] ah, logic [31:0] pay, logic [7:0] t0,
                                int cv, int fe, int fsw, logic [1:0] ec, logic [CH_W-1:0] sel,
                                logic [7:0] op, logic [1:0] pwr);
        vec_t v;
        v.name = nm; v.ah = ah; v.pay = pay; v.t0 = t0; v.n_cv = cv; v.n_fe = fe;
        v.n_fsw = fsw; v.ec = ec; v.sel = sel; v.op = op; v.pwr = pwr;
        return v;
    endfunction

    vec_t vecs[12];

    initial begin
        int cv0, fe0, fsw0, n;

        vecs[0]  = mk("sel1",        1'b0, 32'h00AB0154, 8'h09, 1, 0, 1, 2'd0, 1'b1, 8'h01, 2'b11);
        vecs[1]  = mk("csum",        1'b0, 32'h00AB0155, 8'h09, 0, 1, 0, 2'd2, 1'b1, 8'h01, 2'b11);
        vecs[2]  = mk("sel0",        1'b0, 32'h00AB0055, 8'h09, 1, 0, 1, 2'd2, 1'b0, 8'h00, 2'b11);
        vecs[3]  = mk("pwroff1",     1'b0, 32'h00AB3124, 8'h09, 1, 0, 0, 2'd2, 1'b0, 8'h31, 2'b01);
        vecs[4]  = mk("pwroff_host", 1'b0, 32'h00AB3025, 8'h09, 1, 0, 0, 2'd2, 1'b0, 8'h30, 2'b01);
        vecs[5]  = mk("pwron1",      1'b0, 32'h00AB2134, 8'h09, 1, 0, 0, 2'd2, 1'b0, 8'h21, 2'b11);
        vecs[6]  = mk("badk5",       1'b0, 32'h00AB0550, 8'h09, 0, 1, 0, 2'd3, 1'b0, 8'h21, 2'b11);
        vecs[7]  = mk("badop42",     1'b0, 32'h00AB4213, 8'h09, 0, 1, 0, 2'd3, 1'b0, 8'h21, 2'b11);
        vecs[8]  = mk("other_id",    1'b0, 32'h00CD0132, 8'h09, 0, 0, 0, 2'd3, 1'b0, 8'h21, 2'b11);
        vecs[9]  = mk("tail0",       1'b0, 32'h00AB0154, 8'h08, 0, 1, 0, 2'd2, 1'b0, 8'h21, 2'b11);
        vecs[10] = mk("badk2",       1'b0, 32'h00AB0253, 8'h09, 0, 1, 0, 2'd3, 1'b0, 8'h21, 2'b11);
        vecs[11] = mk("pwroff_h1",   1'b1, 32'h00AB3124, 8'h09, 1, 0, 0, 2'd3, 1'b0, 8'h31, 2'b11);

        rx_if.rx_data  = 8'h00;
        rx_if.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst.cmd_valid", cmd_valid, 0);
        chk("rst.frame_err", frame_err, 0);
        chk("rst.force_swi", force_swi, 0);
        chk("rst.cmd_op",    cmd_op,    0);
        chk("rst.err_code",  err_code,  0);
        chk("rst.sel_host",  sel_host,  0);
        chk("rst.reset_n",   reset_n,   2'b11);
        chk("rst.power_on",  power_on,  2'b11);

        foreach (vecs[i]) begin
            active_host = vecs[i].ah;
            cv0 = cv_cnt; fe0 = fe_cnt; fsw0 = fsw_cnt;
            send_frame(vecs[i].pay, vecs[i].t0);
            chk({vecs[i].name, ".cv_lat"},  cmd_valid, (vecs[i].n_cv == 1));
            chk({vecs[i].name, ".fsw_lat"}, force_swi, (vecs[i].n_fsw == 1));
            repeat (3) @(negedge clk);
            chk({vecs[i].name, ".n_cv"},  cv_cnt - cv0,   vecs[i].n_cv);
            chk({vecs[i].name, ".n_fe"},  fe_cnt - fe0,   vecs[i].n_fe);
            chk({vecs[i].name, ".n_fsw"}, fsw_cnt - fsw0, vecs[i].n_fsw);
            chk({vecs[i].name, ".ec"},    err_code, vecs[i].ec);
            chk({vecs[i].name, ".sel"},   sel_host, vecs[i].sel);
            chk({vecs[i].name, ".op"},    cmd_op,   vecs[i].op);
            chk({vecs[i].name, ".pwr"},   power_on, vecs[i].pwr);
            chk({vecs[i].name, ".rstn"},  reset_n,  2'b11);
        end

        // Header error: EB 91
        active_host = 1'b0;
        fe0 = fe_cnt;
        send_byte(8'hEB);
        send_byte(8'h91);
        chk("hdr.frame_err", frame_err, 1);
        chk("hdr.err_code",  err_code,  0);
        repeat (2) @(negedge clk);
        chk("hdr.n_fe", fe_cnt - fe0, 1);

        // Timeout: EB 90 00 then silence
        fe0 = fe_cnt;
        send_byte(8'hEB);
        send_byte(8'h90);
        send_byte(8'h00);
        repeat (TMO - 1) @(negedge clk);
        chk("tmo.before", frame_err, 0);
        @(negedge clk);
        chk("tmo.frame_err", frame_err, 1);
        chk("tmo.err_code",  err_code,  1);
        @(negedge clk);
        chk("tmo.n_fe", fe_cnt - fe0, 1);

        // Byte exactly in the expiry cycle keeps the frame alive
        fe0 = fe_cnt;
        send_byte(8'hEB);
        send_byte(8'h90);
        send_byte(8'h00);
        repeat (TMO - 1) @(negedge clk);
        send_byte(8'hAB);
        chk("tmo_edge.no_err", frame_err, 0);
        send_byte(8'h01);
        send_byte(8'h54);
        send_byte(8'h09);
        send_byte(8'hD7);
        chk("tmo_edge.cmd_valid", cmd_valid, 1);
        chk("tmo_edge.sel", sel_host, 1);
        @(negedge clk);
        chk("tmo_edge.n_fe", fe_cnt - fe0, 0);
        chk("tmo_edge.err_code", err_code, 1);

        // Reset pulse on ch1 with host 0
        active_host = 1'b0;
        send_frame(32'h00AB1144, 8'h09);
        chk("rp.cmd_valid", cmd_valid, 1);
        chk("rp.exec_rstn", reset_n, 2'b11);
        @(negedge clk);
        chk("rp.rstn_low", reset_n, 2'b01);
        measure_low(1, n);
        chk("rp.width", n, RCYC);
        chk("rp.rstn_end", reset_n, 2'b11);

        // Same opcode targeting the active host: ignored but acknowledged
        active_host = 1'b1;
        send_frame(32'h00AB1144, 8'h09);
        chk("rp_host.cmd_valid", cmd_valid, 1);
        repeat (2) @(negedge clk);
        chk("rp_host.rstn", reset_n, 2'b11);

        // Restart: second request while the pulse is running reloads the count
        active_host = 1'b0;
        send_frame(32'h00AB1144, 8'h09);
        @(negedge clk);
        send_frame(32'h00AB1144, 8'h09);
        chk("rp_re.still_low", reset_n, 2'b01);
        @(negedge clk);
        measure_low(1, n);
        chk("rp_re.width", n, RCYC);

        // 0xFF: all channels reset, host back to 0
        send_frame(32'h00AB0154, 8'h09);
        chk("ff.pre_sel", sel_host, 1);
        fsw0 = fsw_cnt;
        send_frame(32'h00ABFF56, 8'h09);
        chk("ff.cmd_valid", cmd_valid, 1);
        chk("ff.force_swi", force_swi, 1);
        chk("ff.sel", sel_host, 0);
        chk("ff.op", cmd_op, 8'hFF);
        @(negedge clk);
        chk("ff.rstn_low", reset_n, 2'b00);
        measure_low(0, n);
        chk("ff.width", n, RCYC);
        chk("ff.rstn_end", reset_n, 2'b11);

        // Mid-pulse, mid-frame synchronous reset
        send_frame(32'h00AB1144, 8'h09);
        repeat (3) @(negedge clk);
        chk("mid.pulse_running", reset_n, 2'b01);
        send_byte(8'hEB);
        send_byte(8'h90);
        send_byte(8'h00);
        fe0 = fe_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid.rstn", reset_n, 2'b11);
        chk("mid.err_code", err_code, 0);
        chk("mid.cmd_op", cmd_op, 0);
        @(negedge clk);
        chk("mid.n_fe", fe_cnt - fe0, 0);
        send_frame(32'h00AB0154, 8'h09);
        chk("mid.next_cv", cmd_valid, 1);
        chk("mid.next_sel", sel_host, 1);
        chk("mid.next_op", cmd_op, 8'h01);
        @(negedge clk);
        chk("mid.rstn_after", reset_n, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
